// File: rtl/hi_cmd_sequencer_if.sv
// Command/response and HI bus signals of the command sequencer.
// master = sequencer side, slave = local requester plus HI bus environment.
interface hi_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_rdy;
    logic        cmd_write;
    logic [15:0] cmd_term_addr;
    logic [31:0] cmd_reg_addr;
    logic [31:0] cmd_data;

    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_data;
    logic [15:0] rsp_status;
    logic        rsp_timeout;
    logic        busy;

    logic [15:0] di_term_addr;
    logic [31:0] di_reg_addr;
    logic [31:0] di_len;
    logic        di_write_mode;
    logic        di_read_mode;
    logic        di_read_req;
    logic        di_write;
    logic        di_read;
    logic [31:0] di_reg_datai;
    logic        di_write_rdy;
    logic        di_read_rdy;
    logic [31:0] di_reg_datao;
    logic [15:0] di_transfer_status;
    logic        lock_arbiter;

    modport master (
        input  cmd_valid, cmd_write, cmd_term_addr, cmd_reg_addr, cmd_data,
        output cmd_rdy,
        output rsp_valid, rsp_write, rsp_data, rsp_status, rsp_timeout, busy,
        output di_term_addr, di_reg_addr, di_len, di_write_mode, di_read_mode, di_read_req,
        output di_write, di_read, di_reg_datai, lock_arbiter,
        input  di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_term_addr, cmd_reg_addr, cmd_data,
        input  cmd_rdy,
        input  rsp_valid, rsp_write, rsp_data, rsp_status, rsp_timeout, busy,
        input  di_term_addr, di_reg_addr, di_len, di_write_mode, di_read_mode, di_read_req,
        input  di_write, di_read, di_reg_datai, lock_arbiter,
        output di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status
    );
endinterface

// File: rtl/hi_cmd_sequencer.sv
// HI bus master that executes queued single-word register reads/writes, holding the arbiter
// lock across back-to-back queued commands and returning one response per command.
module hi_cmd_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic                ifclk,
    input logic                resetb,
    hi_cmd_sequencer_if.master bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StWaitRdy, StDone} state_e;

    typedef struct packed {
        logic        write;
        logic [15:0] term;
        logic [31:0] regad;
        logic [31:0] data;
    } cmd_t;

    cmd_t            fifo_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rdy_en_q;
    state_e          state_q, state_d;
    cmd_t            act_q, act_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            lock_q, lock_d;
    logic            rsp_write_q, rsp_write_d;
    logic [31:0]     rsp_data_q, rsp_data_d;
    logic [15:0]     rsp_status_q, rsp_status_d;
    logic            rsp_timeout_q, rsp_timeout_d;

    logic empty, full, push, pop, in_xfer, wr_strobe, rd_strobe, tmo_hit;

    assign empty = (count_q == '0);
    assign full  = (count_q == CntW'(DEPTH));
    assign push  = bus.cmd_valid && bus.cmd_rdy;
    assign pop   = (state_q == StIdle) && !empty;

    assign in_xfer   = (state_q == StSetup) || (state_q == StWaitRdy);
    assign wr_strobe = (state_q == StWaitRdy) && act_q.write && bus.di_write_rdy;
    assign rd_strobe = (state_q == StWaitRdy) && !act_q.write && bus.di_read_rdy;
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TmoW'(TIMEOUT - 1));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        act_d         = act_q;
        tmo_d         = tmo_q;
        lock_d        = lock_q;
        rsp_write_d   = rsp_write_q;
        rsp_data_d    = rsp_data_q;
        rsp_status_d  = rsp_status_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    act_d   = fifo_q[rd_ptr_q];
                    lock_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                tmo_d   = '0;
                state_d = StWaitRdy;
            end
            StWaitRdy: begin
                // A strobe on the timeout cycle still completes normally.
                if (wr_strobe || rd_strobe) begin
                    rsp_write_d   = act_q.write;
                    rsp_data_d    = act_q.write ? 32'd0 : bus.di_reg_datao;
                    rsp_status_d  = bus.di_transfer_status;
                    rsp_timeout_d = 1'b0;
                    state_d       = StDone;
                end else if (tmo_hit) begin
                    rsp_write_d   = act_q.write;
                    rsp_data_d    = 32'd0;
                    rsp_status_d  = 16'd0;
                    rsp_timeout_d = 1'b1;
                    state_d       = StDone;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                if (empty) lock_d = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ifclk) begin
        if (push) fifo_q[wr_ptr_q] <= {bus.cmd_write, bus.cmd_term_addr, bus.cmd_reg_addr,
                                       bus.cmd_data};
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            rdy_en_q      <= 1'b0;
            state_q       <= StIdle;
            act_q         <= '0;
            tmo_q         <= '0;
            lock_q        <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_status_q  <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            rdy_en_q      <= 1'b1;
            state_q       <= state_d;
            act_q         <= act_d;
            tmo_q         <= tmo_d;
            lock_q        <= lock_d;
            rsp_write_q   <= rsp_write_d;
            rsp_data_q    <= rsp_data_d;
            rsp_status_q  <= rsp_status_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    // cmd_rdy stays low while in reset and rises on the first clock after release.
    assign bus.cmd_rdy       = rdy_en_q && !full;
    assign bus.busy          = !empty || (state_q != StIdle);
    assign bus.rsp_valid     = (state_q == StDone);
    assign bus.rsp_write     = rsp_write_q;
    assign bus.rsp_data      = rsp_data_q;
    assign bus.rsp_status    = rsp_status_q;
    assign bus.rsp_timeout   = rsp_timeout_q;
    assign bus.di_term_addr  = act_q.term;
    assign bus.di_reg_addr   = act_q.regad;
    assign bus.di_reg_datai  = act_q.data;
    assign bus.di_len        = 32'd4;
    assign bus.di_write_mode = in_xfer && act_q.write;
    assign bus.di_read_mode  = in_xfer && !act_q.write;
    assign bus.di_read_req   = (state_q == StSetup) && !act_q.write;
    assign bus.di_write      = wr_strobe;
    assign bus.di_read       = rd_strobe;
    assign bus.lock_arbiter  = lock_q;

endmodule

// File: tb/tb_hi_cmd_sequencer.sv
// Bench for hi_cmd_sequencer: a reactive HI responder plus a per-command observation record
// compared against records predicted from each command's rdy latency.
module tb_hi_cmd_sequencer;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 16;

    logic ifclk  = 1'b0;
    logic resetb = 1'b0;
    always #5 ifclk = ~ifclk;

    hi_cmd_sequencer_if bus ();

    hi_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .ifclk (ifclk),
        .resetb(resetb),
        .bus   (bus)
    );

    typedef struct {
        int          lat;
        logic [31:0] datao;
        logic [15:0] status;
    } plan_t;

    typedef struct packed {
        logic        w;
        logic [15:0] term;
        logic [31:0] regad;
        logic        stable;
        logic [3:0]  n_wr;
        logic [3:0]  n_rd;
        logic [3:0]  n_req;
        logic [3:0]  n_lock_lo;
        logic [7:0]  n_mode;
        logic [31:0] datai;
        logic        rw;
        logic [31:0] rdata;
        logic [15:0] status;
        logic        to;
    } rec_t;

    plan_t plan_q[$];
    rec_t  exp_q[$];
    rec_t  obs_q[$];
    int    checks = 0;
    int    errors = 0;
    int    stray  = 0;

    // Reference: rdy arrives on WAIT cycle 'lat'; anything past TIMEOUT cycles is a timeout.
    function automatic rec_t make_exp(input logic w, input logic [15:0] term,
                                      input logic [31:0] ra, input logic [31:0] data,
                                      input int lat, input logic [31:0] datao,
                                      input logic [15:0] status);
        rec_t r;
        logic to;
        to = lat > int'(TIMEOUT);
        r = '0;
        r.w      = w;
        r.term   = term;
        r.regad  = ra;
        r.stable = 1'b1;
        r.n_wr   = (w && !to) ? 4'd1 : 4'd0;
        r.n_rd   = (!w && !to) ? 4'd1 : 4'd0;
        r.n_req  = w ? 4'd0 : 4'd1;
        r.n_mode = to ? 8'(TIMEOUT + 1) : 8'(lat + 1);
        r.datai  = (w && !to) ? data : 32'd0;
        r.rw     = w;
        r.rdata  = (w || to) ? 32'd0 : datao;
        r.status = to ? 16'd0 : status;
        r.to     = to;
        return r;
    endfunction

    initial begin : responder
        plan_t cur;
        int    cyc;
        logic  hit;
        cyc = -1;
        cur.lat = 1000;
        bus.di_write_rdy = 1'b0;
        bus.di_read_rdy = 1'b0;
        bus.di_reg_datao = 32'd0;
        bus.di_transfer_status = 16'd0;
        forever begin
            @(negedge ifclk);
            hit = 1'b0;
            if (resetb && (bus.di_write_mode || bus.di_read_mode)) begin
                if (cyc < 0) begin
                    if (plan_q.size() > 0) cur = plan_q.pop_front();
                    else cur.lat = 1000;
                    cyc = 0;
                end else begin
                    cyc++;
                end
                hit = (cyc == cur.lat);
            end else begin
                cyc = -1;
            end
            bus.di_write_rdy = hit && bus.di_write_mode;
            bus.di_read_rdy = hit && bus.di_read_mode;
            bus.di_reg_datao = hit ? cur.datao : $urandom;
            bus.di_transfer_status = hit ? cur.status : 16'($urandom);
        end
    end

    initial begin : monitor
        rec_t cur;
        logic in_cmd;
        in_cmd = 1'b0;
        cur = '0;
        forever begin
            @(negedge ifclk);
            #1;
            if (!resetb) begin
                in_cmd = 1'b0;
            end else begin
                if (!in_cmd && (bus.di_write_mode || bus.di_read_mode)) begin
                    in_cmd = 1'b1;
                    cur = '0;
                    cur.w = bus.di_write_mode;
                    cur.term = bus.di_term_addr;
                    cur.regad = bus.di_reg_addr;
                    cur.stable = 1'b1;
                end
                if (in_cmd) begin
                    if (bus.di_write_mode || bus.di_read_mode) cur.n_mode = cur.n_mode + 8'd1;
                    if (bus.di_term_addr !== cur.term || bus.di_reg_addr !== cur.regad)
                        cur.stable = 1'b0;
                    if (!bus.lock_arbiter) cur.n_lock_lo = cur.n_lock_lo + 4'd1;
                    cur.n_wr = cur.n_wr + {3'd0, bus.di_write};
                    cur.n_rd = cur.n_rd + {3'd0, bus.di_read};
                    cur.n_req = cur.n_req + {3'd0, bus.di_read_req};
                    if (bus.di_write) cur.datai = bus.di_reg_datai;
                    if (bus.rsp_valid) begin
                        cur.rw = bus.rsp_write;
                        cur.rdata = bus.rsp_data;
                        cur.status = bus.rsp_status;
                        cur.to = bus.rsp_timeout;
                        obs_q.push_back(cur);
                        in_cmd = 1'b0;
                    end
                end else if (bus.di_write || bus.di_read || bus.di_read_req || bus.rsp_valid) begin
                    stray++;
                end
            end
        end
    end

    task automatic push_cmd(input logic w, input logic [15:0] term, input logic [31:0] ra,
                            input logic [31:0] data, input int lat, input logic [31:0] datao,
                            input logic [15:0] status);
        plan_t p;
        int    guard;
        guard = 0;
        @(negedge ifclk);
        while (!bus.cmd_rdy && guard < 1000) begin
            @(negedge ifclk);
            guard++;
        end
        checks++;
        if (!bus.cmd_rdy) begin
            errors++;
            $display("FAIL push_wait cmd_rdy got %b required 1 within 1000 cycles", bus.cmd_rdy);
        end
        p.lat = lat;
        p.datao = datao;
        p.status = status;
        plan_q.push_back(p);
        exp_q.push_back(make_exp(w, term, ra, data, lat, datao, status));
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_term_addr = term;
        bus.cmd_reg_addr = ra;
        bus.cmd_data = data;
        @(posedge ifclk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic push_rand(input int lat);
        push_cmd(1'($urandom), 16'($urandom), $urandom, $urandom, lat, $urandom, 16'($urandom));
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge ifclk);
            #2;
            if (obs_q.size() >= exp_q.size() && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (3) @(negedge ifclk);
    endtask

    task automatic test_reset;
        repeat (2) @(negedge ifclk);
        #1;
        checks++;
        if ({bus.cmd_rdy, bus.busy, bus.rsp_valid, bus.lock_arbiter, bus.di_write_mode,
             bus.di_read_mode, bus.di_read_req} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 0", {bus.cmd_rdy, bus.busy,
                     bus.rsp_valid, bus.lock_arbiter, bus.di_write_mode, bus.di_read_mode,
                     bus.di_read_req});
        end
        checks++;
        if (bus.di_len !== 32'd4) begin
            errors++;
            $display("FAIL reset_di_len got %0d required 4", bus.di_len);
        end
        resetb = 1'b1;
        @(posedge ifclk);
        #1;
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rdy/busy got %b%b required 10", bus.cmd_rdy, bus.busy);
        end
    endtask

    task automatic test_single_write;
        bit ok;
        push_cmd(1'b1, 16'h0010, 32'h4, 32'hDEADBEEF, 1, $urandom, 16'h00A5);
        wait_idle(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL write_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL write_rec%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.lock_arbiter !== 1'b0) begin
            errors++;
            $display("FAIL write_lock_after got %b required 0", bus.lock_arbiter);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_single_read;
        bit ok;
        push_cmd(1'b0, 16'h0022, 32'h8, $urandom, 5, 32'h12345678, 16'h0003);
        wait_idle(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL read_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL read_rec%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        bit ok;
        int lo;
        int g;
        lo = 0;
        g = 0;
        push_rand(12);
        while (!(bus.di_write_mode || bus.di_read_mode) && g < 50) begin
            @(negedge ifclk);
            g++;
        end
        // Engine is parked on the first command, so four more pushes fill the FIFO.
        push_cmd(1'b1, 16'($urandom), $urandom, $urandom, 1, $urandom, 16'($urandom));
        push_cmd(1'b0, 16'($urandom), $urandom, $urandom, 2, $urandom, 16'($urandom));
        push_cmd(1'b0, 16'($urandom), $urandom, $urandom, 1, $urandom, 16'($urandom));
        push_cmd(1'b1, 16'($urandom), $urandom, $urandom, 3, $urandom, 16'($urandom));
        checks++;
        if (bus.cmd_rdy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_full cmd_rdy got %b required 0", bus.cmd_rdy);
        end
        for (int n = 0; n < 500 && obs_q.size() < 5; n++) begin
            @(negedge ifclk);
            #2;
            if (!bus.lock_arbiter) lo++;
        end
        checks++;
        if (lo != 0) begin
            errors++;
            $display("FAIL b2b_lock low_cycles got %0d required 0", lo);
        end
        wait_idle(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_rec%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (bus.lock_arbiter !== 1'b0) begin
            errors++;
            $display("FAIL b2b_lock_after got %b required 0", bus.lock_arbiter);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout;
        bit ok;
        push_cmd(1'b1, 16'($urandom), $urandom, $urandom, 100, $urandom, 16'($urandom));
        push_cmd(1'b0, 16'($urandom), $urandom, $urandom, 100, $urandom, 16'($urandom));
        push_cmd(1'b0, 16'($urandom), $urandom, $urandom, 3, $urandom, 16'($urandom));
        push_cmd(1'b0, 16'($urandom), $urandom, $urandom, 16, $urandom, 16'($urandom));
        push_cmd(1'b1, 16'($urandom), $urandom, $urandom, 17, $urandom, 16'($urandom));
        push_cmd(1'b1, 16'($urandom), $urandom, $urandom, 16, $urandom, 16'($urandom));
        push_cmd(1'b0, 16'($urandom), $urandom, $urandom, 17, $urandom, 16'($urandom));
        wait_idle(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL timeout_rec%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        bit ok;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge ifclk);
            push_rand(int'($urandom_range(1, 20)));
        end
        wait_idle(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL random_rec%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid;
        bit ok;
        push_rand(30);
        push_rand(30);
        push_rand(30);
        repeat (5) @(negedge ifclk);
        #3;
        resetb = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_rdy, bus.busy, bus.rsp_valid, bus.lock_arbiter, bus.di_write_mode,
             bus.di_read_mode, bus.di_read_req, bus.di_write, bus.di_read, bus.rsp_timeout,
             bus.rsp_write, bus.di_term_addr, bus.di_reg_addr, bus.di_reg_datai, bus.rsp_data,
             bus.rsp_status} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got nonzero required all 0 (busy %b lock %b term %h)",
                     bus.busy, bus.lock_arbiter, bus.di_term_addr);
        end
        checks++;
        if (bus.di_len !== 32'd4) begin
            errors++;
            $display("FAIL midreset_di_len got %0d required 4", bus.di_len);
        end
        plan_q.delete();
        exp_q.delete();
        obs_q.delete();
        @(negedge ifclk);
        #3;
        resetb = 1'b1;
        @(posedge ifclk);
        #1;
        checks++;
        if (bus.cmd_rdy !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release rdy/busy got %b%b required 10", bus.cmd_rdy, bus.busy);
        end
        repeat (25) @(negedge ifclk);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL midreset_rsp got %0d responses required 0", obs_q.size());
        end
        push_rand(2);
        wait_idle(ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_count got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_rec%0d got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_term_addr = 16'd0;
        bus.cmd_reg_addr = 32'd0;
        bus.cmd_data = 32'd0;
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid();
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL stray_strobes got %0d required 0", stray);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hi_cmd_sequencer.md
# hi_cmd_sequencer

Host Interface master that executes a queue of single-word register reads and writes on the HI bus on behalf of local on-chip logic such as init sequencers and housekeeping FSMs. It presents one host port to the HI multi-host arbiter and holds the arbiter lock across back-to-back queued commands so that a queued burst is atomic. Each command returns exactly one response carrying read data, transfer status and a timeout flag.

## Interface
- DEPTH, 4: command FIFO entries; power of 2, ≥2.
- TIMEOUT, 1024: max cycles waiting for rdy; 0 disables the timeout.
- ifclk  in  1  clock
- resetb  in  1  async active-low reset
- cmd_valid  in  1  command offered
- cmd_rdy  out  1  FIFO not full; push when cmd_valid && cmd_rdy
- cmd_write  in  1  1 = write, 0 = read
- cmd_term_addr  in  16  terminal address
- cmd_reg_addr  in  32  register address
- cmd_data  in  32  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse per completed command
- rsp_write  out  1  echo of cmd_write
- rsp_data  out  32  read data; 0 for writes and timeouts
- rsp_status  out  16  di_transfer_status captured at the strobe; 0 on timeout
- rsp_timeout  out  1  command aborted by timeout
- busy  out  1  FIFO non-empty or state != IDLE
- di_term_addr  out  16, di_reg_addr  out  32  registered from the active command
- di_len  out  32  constant 4 (one 32-bit word, byte count)
- di_write_mode  out  1, di_read_mode  out  1  transaction framing
- di_read_req  out  1  one-cycle pulse that starts a read
- di_write  out  1, di_read  out  1  data strobes
- di_reg_datai  out  32  write data
- di_write_rdy  in  1, di_read_rdy  in  1, di_reg_datao  in  32, di_transfer_status  in  16
- lock_arbiter  out  1  holds the arbiter on this host

## Operation
- FIFO: DEPTH × 81 bits {write, term, reg, data}; count width $clog2(DEPTH)+1; cmd_rdy = !full. When full, cmd_rdy is 0, so no push; pop-with-push when full is therefore impossible.
- FSM states: IDLE, SETUP, WAIT_RDY, DONE.
- IDLE: with the FIFO non-empty, pop the head into the active registers and go to SETUP. All HI strobes and mode outputs are 0.
- SETUP (1 cycle): assert the mode matching the command. For reads, di_read_req = 1 in this cycle only. Go to WAIT_RDY.
- WAIT_RDY: hold the mode. Combinational strobes: di_write = write && di_write_rdy; di_read = !write && di_read_rdy. On a strobe cycle, capture di_reg_datao (reads) and di_transfer_status, then go to DONE. Rdy low for any number of cycles is legal, including the arbiter's host-change cycle.
- Timeout: the counter clears in SETUP and increments each WAIT_RDY cycle without a strobe. When it reaches TIMEOUT, go to DONE with the timeout flag set and assert no strobe. A strobe on that same cycle wins: normal completion, no timeout.
- DONE (1 cycle): both modes 0. rsp_* is registered valid in this cycle. Then go to IDLE.
- lock_arbiter: set on the IDLE→SETUP edge. In DONE it is cleared only if the FIFO is empty; otherwise it stays 1 through IDLE into the next SETUP.
- Reset: state IDLE, FIFO empty, all outputs 0 except di_len = 4 and cmd_rdy = 1 one cycle after reset release. A reset mid-transaction discards the active and queued commands and emits no response.

## Timing
- Push at edge E0. Pop at E1; SETUP is the cycle after E1. WAIT_RDY starts after E2.
- With rdy high: strobe in the first WAIT_RDY cycle; rsp_valid in the following cycle. Minimum command period is 4 cycles.
- The mode is high for ≥2 cycles (SETUP plus ≥1 WAIT_RDY) and drops in DONE.
- Address and data outputs are stable from SETUP through DONE.
- At most one di_write or di_read strobe per command. di_len is never 0.

## Test plan
- Single write: term 0x0010, reg 0x4, data 0xDEADBEEF, write_rdy tied high → write_mode high 2 cycles; one di_write with datai 0xDEADBEEF; rsp_valid 1 cycle later with status captured; lock 0 after DONE.
- Single read: reg 0x8, read_rdy rises 5 cycles after SETUP with datao 0x12345678 → exactly one di_read_req in SETUP; di_read on the rdy cycle; rsp_data 0x12345678, rsp_timeout 0.
- Queue 4 mixed commands back-to-back (DEPTH 4) → cmd_rdy drops after the 4th push; 4 responses in order; lock_arbiter continuously 1 from first SETUP through last DONE.
- TIMEOUT=16, rdy held low → DONE after 16 WAIT_RDY cycles; rsp_timeout 1, rsp_data 0; no strobe; next command proceeds.
- Rdy rises on exactly the 16th WAIT_RDY cycle (TIMEOUT=16) → normal completion; rsp_timeout 0.
- resetb pulsed low during WAIT_RDY with 2 commands queued → all outputs 0 asynchronously; no rsp_valid; FIFO empty and cmd_rdy 1 after release.
